// File: rtl/div_ctrl_pkg.sv
// Shared sizing, mask type and FSM state encoding for the SIMT divergence controller.
package div_ctrl_pkg;

  localparam int N_CORES     = 4;
  localparam int STACK_DEPTH = 3;

  typedef logic [N_CORES-1:0]     mask_t;
  typedef logic [STACK_DEPTH-1:0] depth_t;

  localparam depth_t MAX_DEPTH = '1;
  localparam mask_t  ALL_ONES  = '1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ELSE_PUSH = 2'd1;
  localparam logic [1:0] ST_SKIP      = 2'd2;

endpackage

// File: rtl/div_skip_counter.sv
// Saturating count of IF regions nested inside a skipped region; is_zero marks the matching ENDIF/ELSE level.
module div_skip_counter
  import div_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic is_zero
);

  depth_t cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (inc && cnt != MAX_DEPTH) begin
      cnt <= cnt + 1'b1;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign is_zero = (cnt == '0);

endmodule

// File: rtl/div_ctrl.sv
// Branch-divergence controller feeding the predicate mask stack.
// Build option DIV_SKIP_EN: squash issue inside all-inactive regions via the SKIP state.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic                   op_if,
  input  logic                   op_else,
  input  logic                   op_endif,
  input  logic [N_CORES-1:0]     cond,
  input  logic [N_CORES-1:0]     stk_tos,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [N_CORES-1:0]     stk_d_in,
  output logic                   squash,
  output logic [N_CORES-1:0]     active_mask,
  output logic [STACK_DEPTH-1:0] depth,
  output logic                   err_overflow,
  output logic                   err_underflow
);

`ifdef DIV_SKIP_EN
  localparam logic SKIP_EN = 1'b1;
`else
  localparam logic SKIP_EN = 1'b0;
`endif

  // Handshake: an instruction is consumed on a clk edge where instr_valid && instr_ready;
  // instr_valid is not required to be held, and stack commands are valid only in that cycle.
  logic [1:0] state, state_d;
  depth_t     depth_q, depth_d;
  mask_t      saved_q, saved_d;
  logic       else_seen_q, else_seen_d;
  logic       ovf_q, ovf_d, unf_q, unf_d;
  logic       cnt_clr, cnt_inc, cnt_dec, cnt_zero;
  logic       ready_c, push_c, pop_c, squash_c;
  mask_t      d_in_c;

  div_skip_counter u_skip_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clr),
    .inc     (cnt_inc),
    .dec     (cnt_dec),
    .is_zero (cnt_zero)
  );

  always_comb begin
    state_d     = state;
    depth_d     = depth_q;
    saved_d     = saved_q;
    else_seen_d = else_seen_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    cnt_dec     = 1'b0;
    ready_c     = 1'b0;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    squash_c    = 1'b0;
    d_in_c      = '0;
    case (state)
      ST_IDLE: begin
        ready_c = 1'b1;
        if (instr_valid) begin
          if (op_if) begin
            if (depth_q != MAX_DEPTH) begin
              push_c  = 1'b1;
              d_in_c  = stk_tos & cond;
              depth_d = depth_q + 1'b1;
              if (SKIP_EN && (stk_tos & cond) == '0) begin
                state_d     = ST_SKIP;
                cnt_clr     = 1'b1;
                else_seen_d = 1'b0;
              end
            end else begin
              ovf_d = 1'b1;
            end
          end else if (op_else) begin
            if (depth_q != '0) begin
              saved_d = stk_tos;
              pop_c   = 1'b1;
              state_d = ST_ELSE_PUSH;
            end else begin
              unf_d = 1'b1;
            end
          end else if (op_endif) begin
            if (depth_q != '0) begin
              pop_c   = 1'b1;
              depth_d = depth_q - 1'b1;
            end else begin
              unf_d = 1'b1;
            end
          end
        end
      end
      ST_ELSE_PUSH: begin
        // The IF-side mask was popped last cycle, so stk_tos is the parent here.
        push_c  = 1'b1;
        d_in_c  = stk_tos & ~saved_q;
        state_d = ST_IDLE;
        if (SKIP_EN && (stk_tos & ~saved_q) == '0) begin
          state_d     = ST_SKIP;
          cnt_clr     = 1'b1;
          else_seen_d = 1'b1;
        end
      end
      ST_SKIP: begin
        ready_c  = 1'b1;
        squash_c = 1'b1;
        if (instr_valid) begin
          if (op_if) begin
            cnt_inc = 1'b1;
          end else if (op_endif) begin
            if (!cnt_zero) begin
              cnt_dec = 1'b1;
            end else begin
              pop_c    = 1'b1;
              depth_d  = depth_q - 1'b1;
              state_d  = ST_IDLE;
              squash_c = 1'b0;
            end
          end else if (op_else && cnt_zero && !else_seen_q) begin
            saved_d  = stk_tos;
            pop_c    = 1'b1;
            state_d  = ST_ELSE_PUSH;
            squash_c = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (reset) begin
      ready_c  = 1'b0;
      push_c   = 1'b0;
      pop_c    = 1'b0;
      squash_c = 1'b0;
      d_in_c   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      depth_q     <= '0;
      saved_q     <= '0;
      else_seen_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state       <= state_d;
      depth_q     <= depth_d;
      saved_q     <= saved_d;
      else_seen_q <= else_seen_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign instr_ready   = ready_c;
  assign stk_push      = push_c;
  assign stk_pop       = pop_c;
  assign stk_d_in      = d_in_c;
  assign squash        = squash_c;
  assign active_mask   = (reset || squash_c) ? '0 : stk_tos;
  assign depth         = reset ? '0 : depth_q;
  assign err_overflow  = ovf_q & ~reset;
  assign err_underflow = unf_q & ~reset;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the stack is modelled by the stk_tos value driven at each step.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam logic [2:0] OP_NONE  = 3'b000;
  localparam logic [2:0] OP_IF    = 3'b100;
  localparam logic [2:0] OP_ELSE  = 3'b010;
  localparam logic [2:0] OP_ENDIF = 3'b001;
  localparam int W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic instr_valid = 1'b0;
  logic op_if = 1'b0, op_else = 1'b0, op_endif = 1'b0;
  logic [N_CORES-1:0] cond = '0, stk_tos = '0;
  logic instr_ready, stk_push, stk_pop, squash, err_overflow, err_underflow;
  logic [N_CORES-1:0] stk_d_in, active_mask;
  logic [STACK_DEPTH-1:0] depth;

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op_if(op_if), .op_else(op_else), .op_endif(op_endif), .cond(cond), .stk_tos(stk_tos),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_d_in(stk_d_in), .squash(squash),
    .active_mask(active_mask), .depth(depth), .err_overflow(err_overflow),
    .err_underflow(err_underflow)
  );

  function automatic logic [W-1:0] r(input logic rdy, input logic psh, input logic pp,
                                     input logic [3:0] din, input logic sq, input logic [3:0] am);
    return {rdy, psh, pp, din, sq, am};
  endfunction

  // Drive at negedge, compare combinational outputs mid-low phase, return just after posedge.
  task automatic do_step(input string tag, input logic rst, input logic v, input logic [2:0] op,
                         input logic [3:0] c, input logic [3:0] tos, input logic [W-1:0] exp);
    logic [W-1:0] obs, e;
    @(negedge clk);
    reset = rst;
    instr_valid = v;
    {op_if, op_else, op_endif} = op;
    cond = c;
    stk_tos = tos;
    exp_q.push_back(exp);
    #2;
    obs = {instr_ready, stk_push, stk_pop, stk_d_in, squash, active_mask};
    e = exp_q.pop_front();
    n_cmp++;
    assert (obs === e) else begin
      n_err++;
      $error("FAIL %s: observed rdy/push/pop/din/sq/am=%b expected %b", tag, obs, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset: outputs forced low even with an IF presented.
    do_step("reset_out", 1'b1, 1'b1, OP_IF, 4'b1111, 4'b1111, r(0,0,0,4'b0000,0,4'b0000));
    do_step("reset_out2", 1'b1, 1'b0, OP_NONE, 4'b0000, 4'b1111, r(0,0,0,4'b0000,0,4'b0000));
    chk("reset_depth", depth, 0);
    chk("reset_ovf", err_overflow, 0);
    chk("reset_unf", err_underflow, 0);

    // Simple IF / ENDIF.
    do_step("if_0101", 1'b0, 1'b1, OP_IF, 4'b0101, 4'b1111, r(1,1,0,4'b0101,0,4'b1111));
    chk("if_depth", depth, 1);
    do_step("endif_1", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b0101, r(1,0,1,4'b0000,0,4'b0101));
    chk("endif_depth", depth, 0);

    // IF / ELSE: pop then push of the complement under the parent.
    do_step("if_0011", 1'b0, 1'b1, OP_IF, 4'b0011, 4'b1111, r(1,1,0,4'b0011,0,4'b1111));
    do_step("else_pop", 1'b0, 1'b1, OP_ELSE, 4'b0000, 4'b0011, r(1,0,1,4'b0000,0,4'b0011));
    do_step("else_push", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(0,1,0,4'b1100,0,4'b1111));
    chk("else_depth", depth, 1);
    do_step("else_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b1100, r(1,0,1,4'b0000,0,4'b1100));
    chk("else_endif_depth", depth, 0);

    // All-inactive IF region with a nested IF/ENDIF, then the outer ELSE.
    do_step("if_zero", 1'b0, 1'b1, OP_IF, 4'b0000, 4'b1111, r(1,1,0,4'b0000,0,4'b1111));
    chk("if_zero_depth", depth, 1);
`ifdef DIV_SKIP_EN
    do_step("skip_nested_if", 1'b0, 1'b1, OP_IF, 4'b1111, 4'b0000, r(1,0,0,4'b0000,1,4'b0000));
    chk("skip_nested_depth", depth, 1);
    do_step("skip_normal", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b0000, r(1,0,0,4'b0000,1,4'b0000));
    do_step("skip_nested_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b0000, r(1,0,0,4'b0000,1,4'b0000));
    chk("skip_nested_endif_depth", depth, 1);
`else
    do_step("zero_nested_if", 1'b0, 1'b1, OP_IF, 4'b1111, 4'b0000, r(1,1,0,4'b0000,0,4'b0000));
    chk("zero_nested_depth", depth, 2);
    do_step("zero_normal", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b0000, r(1,0,0,4'b0000,0,4'b0000));
    do_step("zero_nested_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b0000, r(1,0,1,4'b0000,0,4'b0000));
    chk("zero_nested_endif_depth", depth, 1);
`endif
    do_step("outer_else_pop", 1'b0, 1'b1, OP_ELSE, 4'b0000, 4'b0000, r(1,0,1,4'b0000,0,4'b0000));
    do_step("outer_else_push", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(0,1,0,4'b1111,0,4'b1111));
    do_step("outer_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b1111, r(1,0,1,4'b0000,0,4'b1111));
    chk("outer_endif_depth", depth, 0);

    // IF all-active, ELSE pushes an empty mask.
    do_step("if_full", 1'b0, 1'b1, OP_IF, 4'b1111, 4'b1111, r(1,1,0,4'b1111,0,4'b1111));
    do_step("full_else_pop", 1'b0, 1'b1, OP_ELSE, 4'b0000, 4'b1111, r(1,0,1,4'b0000,0,4'b1111));
    do_step("full_else_push", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(0,1,0,4'b0000,0,4'b1111));
`ifdef DIV_SKIP_EN
    do_step("empty_else_body", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b0000, r(1,0,0,4'b0000,1,4'b0000));
    do_step("second_else_ignored", 1'b0, 1'b1, OP_ELSE, 4'b0000, 4'b0000, r(1,0,0,4'b0000,1,4'b0000));
`else
    do_step("empty_else_body", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b0000, r(1,0,0,4'b0000,0,4'b0000));
`endif
    do_step("empty_else_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b0000, r(1,0,1,4'b0000,0,4'b0000));
    chk("empty_else_depth", depth, 0);

    // Nest to maximum depth, then one more IF overflows.
    for (int i = 1; i <= 7; i++) begin
      do_step("nest_if", 1'b0, 1'b1, OP_IF, 4'b1111, 4'b1111, r(1,1,0,4'b1111,0,4'b1111));
      chk("nest_depth", depth, 8'(i));
    end
    chk("ovf_before", err_overflow, 0);
    do_step("overflow_if", 1'b0, 1'b1, OP_IF, 4'b1111, 4'b1111, r(1,0,0,4'b0000,0,4'b1111));
    chk("ovf_depth", depth, 7);
    chk("ovf_set", err_overflow, 1);
    do_step("after_ovf", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(1,0,0,4'b0000,0,4'b1111));
    chk("ovf_sticky", err_overflow, 1);
    for (int i = 6; i >= 0; i--) begin
      do_step("unnest_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b1111, r(1,0,1,4'b0000,0,4'b1111));
      chk("unnest_depth", depth, 8'(i));
    end
    chk("ovf_sticky2", err_overflow, 1);

    // ENDIF at depth 0.
    do_step("underflow_endif", 1'b0, 1'b1, OP_ENDIF, 4'b0000, 4'b1111, r(1,0,0,4'b0000,0,4'b1111));
    chk("unf_set", err_underflow, 1);
    chk("unf_depth", depth, 0);

    // Reset while in ELSE_PUSH.
    do_step("rst_if", 1'b0, 1'b1, OP_IF, 4'b0110, 4'b1111, r(1,1,0,4'b0110,0,4'b1111));
    do_step("rst_else_pop", 1'b0, 1'b1, OP_ELSE, 4'b0000, 4'b0110, r(1,0,1,4'b0000,0,4'b0110));
    do_step("rst_in_else_push", 1'b1, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(0,0,0,4'b0000,0,4'b0000));
    chk("rst_state", dut.state, ST_IDLE);
    chk("rst_depth", depth, 0);
    chk("rst_ovf", err_overflow, 0);
    chk("rst_unf", err_underflow, 0);
    do_step("post_rst_idle", 1'b0, 1'b1, OP_NONE, 4'b0000, 4'b1111, r(1,0,0,4'b0000,0,4'b1111));
    chk("exp_q_drained", 8'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
